qbert_move_ctrl: RTL and testbench
==================================

Name: qbert_move_ctrl

Overview:
Sequencer for the Q*bert sprite layer. It accepts direction requests from the NIOS or the keyboard/accelerometer path and tracks Q*bert's cube position on the 7-row, 28-cube pyramid. For each jump it issues the command, target, bad-jump and win flags to the sprite layer, then waits for the layer's handshakes before committing the move. It also maintains the visited-cube mask, the visited count, lives, game-over and a watchdog error.

Parameters:
N_ROWS, 7, pyramid rows; cube count is N_ROWS*(N_ROWS+1)/2.
N_CUBE, 28, visited count that wins the level; must equal the cube count.
LIVES, 3, lives loaded at reset and on restart.
TIMEOUT, 32'd50_000_000, maximum cycles spent waiting on the layer in any wait state.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
e_start  in  1  restart pulse; highest priority after reset
dir_valid  in  1  direction request valid
dir  in  3  1=DOWN_RIGHT 2=DOWN_LEFT 3=UP_RIGHT 4=UP_LEFT; other codes illegal
dir_ready  out  1  high only in READY
done_move  in  1  layer move-done level
state_qb  in  3  layer state: 000 START, 001 JUMP, 010 IDLE, 011 SAUCER, 100 KO
e_jump_qb  out  3  jump command to layer; 0 = none
position_qb  out  28  one-hot current cube; bit i = index i
e_next_qb  out  28  one-hot target cube; all-zero = off-pyramid
e_bad_jump  out  1  issued target is off-pyramid
e_win_qb  out  1  issued target completes the level
visited  out  28  visited-cube mask
visited_cnt  out  5  popcount of visited
lives  out  2  remaining lives
game_over  out  1  high in GAME_OVER
timeout_err  out  1  sticky watchdog flag
ctrl_state  out  3  FSM state encoding, for NIOS debug

Behaviour:
- Position held internally as row r (0..N_ROWS-1) and column c (0..r). Index = r*(r+1)/2 + c. position_qb = 1<<index.
- Target rules:
  - DOWN_RIGHT: (r+1, c+1).
  - DOWN_LEFT: (r+1, c).
  - UP_RIGHT: (r-1, c), legal only if r>0 and c<=r-1.
  - UP_LEFT: (r-1, c-1), legal only if r>0 and c>0.
  - A down jump from r=N_ROWS-1 is off-pyramid.
- Reset and e_start (all registered, effective the next cycle):
  - r=c=0; position_qb = e_next_qb = 28'h1; visited = 28'h1; visited_cnt = 1.
  - e_jump_qb=0, e_bad_jump=0, e_win_qb=0, lives=LIVES, game_over=0, dir_ready=0.
  - FSM goes to WAIT_START; watchdog count=0.
  - timeout_err clears on reset only, not on e_start.
- FSM:
  - WAIT_START (0): when state_qb==010, go to READY.
  - READY (1): dir_ready=1. If dir_valid with a legal code (1..4), in that cycle register the issue outputs and go to WAIT_LOW:
    - e_jump_qb <= dir.
    - e_next_qb <= one-hot of the target, or 0 if off-pyramid.
    - e_bad_jump <= off-pyramid.
    - e_win_qb <= !off && !visited[target] && visited_cnt+1==N_CUBE.
    - Illegal codes and dir_valid=0 are ignored; the FSM stays in READY.
  - WAIT_LOW (2): when done_move==0 (the layer has left IDLE), go to WAIT_HIGH.
  - WAIT_HIGH (3): when done_move==1, commit the move and clear e_jump_qb to 0.
    - Legal target: update r/c and position_qb; set the visited bit; increment visited_cnt only if the bit was clear. Go to WIN if e_win_qb, else READY.
    - Off-pyramid: lives--; r=c=0; position_qb = e_next_qb = 28'h1; e_bad_jump stays high until KO is seen. Go to GAME_OVER if lives was 1, else KO_WAIT.
  - KO_WAIT (4): when state_qb==100, clear e_bad_jump and go to WAIT_START.
  - WIN (5): e_win_qb held high; leaves only on e_start or reset.
  - GAME_OVER (6): game_over=1; leaves only on e_start or reset.
- Watchdog:
  - Counts cycles in WAIT_START, WAIT_LOW, WAIT_HIGH and KO_WAIT; clears on every state change.
  - Reaching TIMEOUT sets timeout_err, clears e_jump_qb and e_bad_jump, and goes to WAIT_START. Position is unchanged.
- Simultaneous events:
  - reset beats e_start, which beats all FSM activity.
  - dir_valid outside READY is dropped, not queued.
  - A direction request in the same cycle as done_move is sampled only if the FSM is in READY.
- lives saturates at 0; visited_cnt never exceeds N_CUBE.

Test Plan:
- Reset; drive state_qb=010 -> READY, position_qb=28'h1, visited_cnt=1, lives=3, dir_ready=1.
- In READY, dir=2 -> next cycle e_jump_qb=2, e_next_qb=28'h2, e_bad_jump=0. Then done_move 0, then 1 -> position_qb=28'h2, visited=28'h3, visited_cnt=2, state READY.
- At top, dir=4 -> e_next_qb=0, e_bad_jump=1. done_move 0, then 1 -> lives=2, position_qb=28'h1, KO_WAIT. state_qb=100 -> e_bad_jump=0, WAIT_START.
- With 27 cubes visited, jump to the last unvisited cube -> e_win_qb=1 at issue. On landing -> WIN, visited=28'hFFFFFFF, visited_cnt=28. Then e_start -> READY path restored, visited=28'h1.
- Three consecutive bad jumps -> lives 3→2→1→0, game_over=1, dir_valid ignored. e_start -> lives=3, game_over=0.
- TIMEOUT=100; issue a jump and hold done_move=1 -> after 100 cycles timeout_err=1, e_jump_qb=0, WAIT_START. dir=7 in READY ignored, dir_ready stays 1.

Source files
------------

// File: rtl/qbert_move_ctrl.sv
// Q*bert jump sequencer: issues one jump at a time to the sprite layer, waits for the
// layer's done_move handshake, then commits the move and updates visited, lives and win state.
module qbert_move_ctrl #(
    parameter int          N_ROWS  = 7,
    parameter int          N_CUBE  = 28,
    parameter int          LIVES   = 3,
    parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic        dir_valid,
    input  logic [2:0]  dir,
    output logic        dir_ready,
    input  logic        done_move,
    input  logic [2:0]  state_qb,
    output logic [2:0]  e_jump_qb,
    output logic [27:0] position_qb,
    output logic [27:0] e_next_qb,
    output logic        e_bad_jump,
    output logic        e_win_qb,
    output logic [27:0] visited,
    output logic [4:0]  visited_cnt,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        timeout_err,
    output logic [2:0]  ctrl_state
);

    typedef enum logic [2:0] {
        S_WAIT_START = 3'd0,
        S_READY      = 3'd1,
        S_WAIT_LOW   = 3'd2,
        S_WAIT_HIGH  = 3'd3,
        S_KO_WAIT    = 3'd4,
        S_WIN        = 3'd5,
        S_GAME_OVER  = 3'd6
    } state_t;

    localparam logic [2:0] LAST_ROW = 3'(N_ROWS - 1);
    localparam logic [2:0] QB_IDLE  = 3'b010;
    localparam logic [2:0] QB_KO    = 3'b100;

    state_t      state_q;
    logic [2:0]  r_q, c_q, tr_q, tc_q;
    logic [27:0] pos_q, next_q, vis_q;
    logic [4:0]  cnt_q;
    logic [1:0]  lives_q;
    logic [2:0]  jump_q;
    logic        bad_q, win_q, to_q;
    logic [31:0] wd_q;

    logic [2:0]  tgt_r, tgt_c;
    logic        tgt_off;
    logic [4:0]  tgt_idx;
    logic [27:0] tgt_onehot;
    logic        dir_legal, is_wait, advance, wd_expire;

    // Linear cube index: rows above contribute a triangular number of cubes.
    function automatic logic [4:0] cube_idx(input logic [2:0] row, input logic [2:0] col);
        logic [5:0] tri2;
        tri2 = {3'b000, row} * ({3'b000, row} + 6'd1);
        return tri2[5:1] + {2'b00, col};
    endfunction

    always_comb begin
        tgt_r   = r_q;
        tgt_c   = c_q;
        tgt_off = 1'b0;
        case (dir)
            3'd1: begin
                tgt_r   = r_q + 3'd1;
                tgt_c   = c_q + 3'd1;
                tgt_off = (r_q == LAST_ROW);
            end
            3'd2: begin
                tgt_r   = r_q + 3'd1;
                tgt_off = (r_q == LAST_ROW);
            end
            3'd3: begin
                if (r_q != 3'd0 && c_q < r_q) tgt_r = r_q - 3'd1;
                else                         tgt_off = 1'b1;
            end
            3'd4: begin
                if (r_q != 3'd0 && c_q != 3'd0) begin
                    tgt_r = r_q - 3'd1;
                    tgt_c = c_q - 3'd1;
                end else begin
                    tgt_off = 1'b1;
                end
            end
            default: tgt_off = 1'b1;
        endcase
    end

    assign tgt_idx    = cube_idx(tgt_r, tgt_c);
    assign tgt_onehot = tgt_off ? 28'd0 : (28'd1 << tgt_idx);
    assign dir_legal  = (dir >= 3'd1) && (dir <= 3'd4);

    always_comb begin
        advance = 1'b0;
        case (state_q)
            S_WAIT_START: advance = (state_qb == QB_IDLE);
            S_WAIT_LOW:   advance = !done_move;
            S_WAIT_HIGH:  advance = done_move;
            S_KO_WAIT:    advance = (state_qb == QB_KO);
            default:      advance = 1'b0;
        endcase
    end

    assign is_wait   = (state_q == S_WAIT_START) || (state_q == S_WAIT_LOW) ||
                       (state_q == S_WAIT_HIGH)  || (state_q == S_KO_WAIT);
    assign wd_expire = (wd_q == TIMEOUT - 32'd1);

    always_ff @(posedge clk) begin
        if (reset || e_start) begin
            state_q <= S_WAIT_START;
            r_q     <= 3'd0;
            c_q     <= 3'd0;
            tr_q    <= 3'd0;
            tc_q    <= 3'd0;
            pos_q   <= 28'h1;
            next_q  <= 28'h1;
            vis_q   <= 28'h1;
            cnt_q   <= 5'd1;
            lives_q <= 2'(LIVES);
            jump_q  <= 3'd0;
            bad_q   <= 1'b0;
            win_q   <= 1'b0;
            wd_q    <= 32'd0;
            if (reset) to_q <= 1'b0;
        end else if (is_wait && !advance && wd_expire) begin
            // Layer stopped responding: abandon the jump but keep the position.
            to_q    <= 1'b1;
            jump_q  <= 3'd0;
            bad_q   <= 1'b0;
            wd_q    <= 32'd0;
            state_q <= S_WAIT_START;
        end else begin
            wd_q <= is_wait ? wd_q + 32'd1 : 32'd0;
            case (state_q)
                S_WAIT_START: if (advance) begin
                    state_q <= S_READY;
                    wd_q    <= 32'd0;
                end
                S_READY: if (dir_valid && dir_legal) begin
                    jump_q  <= dir;
                    next_q  <= tgt_onehot;
                    bad_q   <= tgt_off;
                    win_q   <= !tgt_off && !vis_q[tgt_idx] && (cnt_q + 5'd1 == 5'(N_CUBE));
                    tr_q    <= tgt_r;
                    tc_q    <= tgt_c;
                    state_q <= S_WAIT_LOW;
                end
                S_WAIT_LOW: if (advance) begin
                    state_q <= S_WAIT_HIGH;
                    wd_q    <= 32'd0;
                end
                S_WAIT_HIGH: if (advance) begin
                    jump_q <= 3'd0;
                    wd_q   <= 32'd0;
                    if (!bad_q) begin
                        r_q   <= tr_q;
                        c_q   <= tc_q;
                        pos_q <= next_q;
                        vis_q <= vis_q | next_q;
                        if ((vis_q & next_q) == 28'd0 && cnt_q != 5'(N_CUBE))
                            cnt_q <= cnt_q + 5'd1;
                        state_q <= win_q ? S_WIN : S_READY;
                    end else begin
                        lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                        r_q     <= 3'd0;
                        c_q     <= 3'd0;
                        pos_q   <= 28'h1;
                        next_q  <= 28'h1;
                        state_q <= (lives_q <= 2'd1) ? S_GAME_OVER : S_KO_WAIT;
                    end
                end
                S_KO_WAIT: if (advance) begin
                    bad_q   <= 1'b0;
                    wd_q    <= 32'd0;
                    state_q <= S_WAIT_START;
                end
                default: ;
            endcase
        end
    end

    assign dir_ready   = (state_q == S_READY);
    assign game_over   = (state_q == S_GAME_OVER);
    assign e_jump_qb   = jump_q;
    assign position_qb = pos_q;
    assign e_next_qb   = next_q;
    assign e_bad_jump  = bad_q;
    assign e_win_qb    = win_q;
    assign visited     = vis_q;
    assign visited_cnt = cnt_q;
    assign lives       = lives_q;
    assign timeout_err = to_q;
    assign ctrl_state  = state_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Bench for qbert_move_ctrl: pyramid geometry model, directed game scenarios and random play.
module tb_qbert_move_ctrl;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset, e_start, dir_valid, done_move;
  logic [2:0] dir, state_qb;
  logic dir_ready, e_bad_jump, e_win_qb, game_over, timeout_err;
  logic [2:0] e_jump_qb, ctrl_state;
  logic [27:0] position_qb, e_next_qb, visited;
  logic [4:0] visited_cnt;
  logic [1:0] lives;

  qbert_move_ctrl #(.TIMEOUT(32'd100)) dut (
    .clk(clk), .reset(reset), .e_start(e_start), .dir_valid(dir_valid), .dir(dir),
    .dir_ready(dir_ready), .done_move(done_move), .state_qb(state_qb),
    .e_jump_qb(e_jump_qb), .position_qb(position_qb), .e_next_qb(e_next_qb),
    .e_bad_jump(e_bad_jump), .e_win_qb(e_win_qb), .visited(visited),
    .visited_cnt(visited_cnt), .lives(lives), .game_over(game_over),
    .timeout_err(timeout_err), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: geometric position, visited set, lives and game phase
  int m_r, m_c, m_state, m_lives, m_jump;
  logic [27:0] m_vis, m_next;
  bit m_bad, m_win, m_to;
  int rr[28], cc[28];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(int r, int c);
    return r * (r + 1) / 2 + c;
  endfunction

  function automatic bit model_target(input int r, input int c, input int d,
                                      output int nr, output int nc);
    nr = r; nc = c;
    case (d)
      1: begin nr = r + 1; nc = c + 1; end
      2: begin nr = r + 1; nc = c;     end
      3: begin nr = r - 1; nc = c;     end
      4: begin nr = r - 1; nc = c - 1; end
      default: return 1'b0;
    endcase
    return (nr >= 0) && (nr < 7) && (nc >= 0) && (nc <= nr);
  endfunction

  // first move of a shortest path to any unvisited cube
  function automatic int bfs_move();
    int q[$];
    bit seen[28];
    int first[28];
    int u, v, nr, nc, start;
    for (int i = 0; i < 28; i++) begin seen[i] = 1'b0; first[i] = 1; end
    start = idx_of(m_r, m_c);
    seen[start] = 1'b1;
    q.push_back(start);
    while (q.size() > 0) begin
      u = q.pop_front();
      for (int d = 1; d <= 4; d++) begin
        if (model_target(rr[u], cc[u], d, nr, nc)) begin
          v = idx_of(nr, nc);
          if (!seen[v]) begin
            seen[v] = 1'b1;
            first[v] = (u == start) ? d : first[u];
            if (!m_vis[v]) return first[v];
            q.push_back(v);
          end
        end
      end
    end
    return 1;
  endfunction

  task automatic model_restart();
    m_r = 0; m_c = 0; m_vis = 28'h1; m_lives = 3; m_state = 0;
    m_jump = 0; m_next = 28'h1; m_bad = 0; m_win = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(ctrl_state), m_state);
    check({tag, ".pos"}, 32'(position_qb), 32'd1 << idx_of(m_r, m_c));
    check({tag, ".visited"}, 32'(visited), 32'(m_vis));
    check({tag, ".cnt"}, 32'(visited_cnt), $countones(m_vis));
    check({tag, ".lives"}, 32'(lives), m_lives);
    check({tag, ".game_over"}, 32'(game_over), 32'(m_state == 6));
    check({tag, ".dir_ready"}, 32'(dir_ready), 32'(m_state == 1));
    check({tag, ".jump"}, 32'(e_jump_qb), m_jump);
    check({tag, ".next"}, 32'(e_next_qb), 32'(m_next));
    check({tag, ".bad"}, 32'(e_bad_jump), 32'(m_bad));
    check({tag, ".win"}, 32'(e_win_qb), 32'(m_win));
    check({tag, ".timeout"}, 32'(timeout_err), 32'(m_to));
  endtask

  task automatic go_ready();
    state_qb = 3'b010;
    step();
    state_qb = 3'b001;
    m_state = 1;
    check_all("ready");
  endtask

  task automatic restart();
    e_start = 1'b1;
    step();
    e_start = 1'b0;
    model_restart();
    check_all("restart");
    go_ready();
  endtask

  task automatic do_jump(input int d);
    bit on;
    int nr, nc, ti;
    on = model_target(m_r, m_c, d, nr, nc);
    ti = on ? idx_of(nr, nc) : 0;
    dir_valid = 1'b1; dir = 3'(d);
    step();
    dir_valid = 1'b0;
    m_jump = d; m_bad = !on;
    m_next = on ? (28'd1 << ti) : 28'd0;
    m_win = on && !m_vis[ti] && ($countones(m_vis) + 1 == 28);
    m_state = 2;
    check_all("issue");
    // a request while busy must be dropped, including in the done_move cycle
    done_move = 1'b0; dir_valid = 1'b1; dir = 3'($urandom_range(1, 4));
    step();
    m_state = 3;
    check_all("wait_high");
    done_move = 1'b1;
    step();
    dir_valid = 1'b0;
    m_jump = 0;
    if (on) begin
      m_r = nr; m_c = nc; m_vis[ti] = 1'b1;
      m_state = m_win ? 5 : 1;
    end else begin
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      m_r = 0; m_c = 0; m_next = 28'h1;
      m_state = (m_lives == 0) ? 6 : 4;
    end
    check_all("commit");
    if (m_state == 4) begin
      state_qb = 3'b100;
      step();
      state_qb = 3'b001;
      m_bad = 0; m_state = 0;
      check_all("ko");
      go_ready();
    end
  endtask

  task automatic ignored_req(input int d, input string tag);
    dir_valid = 1'b1; dir = 3'(d);
    step();
    dir_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int d, guard;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c <= r; c++) begin rr[idx_of(r, c)] = r; cc[idx_of(r, c)] = c; end
    reset = 1'b1; e_start = 1'b0; dir_valid = 1'b0; dir = 3'd0;
    done_move = 1'b1; state_qb = 3'b001;
    step(); step();
    reset = 1'b0;
    model_restart(); m_to = 0;
    check_all("reset");
    go_ready();

    // first legal jump down-left
    do_jump(2);
    check("tp_pos", 32'(position_qb), 32'h2);
    check("tp_visited", 32'(visited), 32'h3);

    // three bad jumps from the top drain all lives
    restart();
    do_jump(4);
    do_jump(4);
    do_jump(4);
    check("go_flag", 32'(game_over), 32'd1);
    ignored_req(1, "go_ignore");
    restart();

    // walk the whole pyramid until the level is won
    guard = 0;
    while (m_state == 1 && guard < 300) begin
      do_jump(bfs_move());
      guard++;
    end
    check("win_state", 32'(ctrl_state), 32'd5);
    check("win_visited", 32'(visited), 32'hFFFFFFF);
    ignored_req(2, "win_hold");
    restart();

    // layer never drops done_move: watchdog fires after TO cycles in WAIT_LOW
    dir_valid = 1'b1; dir = 3'd2;
    step();
    dir_valid = 1'b0;
    m_jump = 2; m_next = 28'h2; m_bad = 0; m_win = 0; m_state = 2;
    check_all("wd_issue");
    repeat (TO - 1) step();
    check_all("wd_before");
    step();
    m_to = 1; m_jump = 0; m_bad = 0; m_state = 0;
    check_all("wd_fire");
    go_ready();
    ignored_req(7, "illegal7");
    restart();

    // random play against the model
    for (int i = 0; i < 400; i++) begin
      if (m_state == 1) begin
        d = $urandom_range(0, 11);
        if (d >= 1 && d <= 4) do_jump(d);
        else if (d == 0 || d <= 7) ignored_req(d, "illegal");
        else begin
          dir = 3'($urandom_range(1, 4));
          step();
          check_all("idle");
        end
      end else if (m_state == 6) begin
        ignored_req($urandom_range(1, 4), "go_ignore");
        restart();
      end else begin
        restart();
      end
    end

    // only reset clears the sticky watchdog flag
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_restart(); m_to = 0;
    check_all("final_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
